line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
// PURPOSE
//   Sequencer for the KERNEL_WIDTH-line buffer chain feeding the HOG gradient/cell stages.
//   Tracks the raster position of the incoming pixel stream.
//   Gates writes into the line-buffer FIFOs and decides when the buffered window is legal.
//   Emits one kernel-valid handshake per legal window plus the window's top-left coordinate.
//   Sits between the pixel source and the line buffer, and in front of the kernel consumer.
// PARAMETERS
//   IMG_WIDTH    854  pixels per line; must be >= KERNEL_WIDTH
//   IMG_HEIGHT   480  lines per frame; must be >= KERNEL_WIDTH
//   KERNEL_WIDTH 3    square window size; 2..8
//   COL_W  $clog2(IMG_WIDTH)   column counter width (localparam)
//   ROW_W  $clog2(IMG_HEIGHT)  row counter width (localparam)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      upstream pixel valid
//   in_ready    out  1      upstream pixel accept
//   lb_write    out  1      write strobe to line-buffer chain (= in_valid && in_ready)
//   out_valid   out  1      kernel window valid to consumer
//   out_ready   in   1      consumer accepts window
//   win_col     out  COL_W  top-left column of presented window
//   win_row     out  ROW_W  top-left row of presented window
//   border      out  1      registered pulse: accepted pixel completes no legal window (row ready, col < K-1)
//   frame_done  out  1      one-cycle pulse after last pixel of frame accepted
// BEHAVIOUR
//   Reset values
//   - All outputs 0; win_col/win_row 0; col/row counters 0; state S_FILL.
//   Handshake
//   - accept = in_valid && in_ready.
//   - in_ready = (state != S_DONE) && (!out_valid || out_ready). There is no skid buffer.
//   - A stalled window holds out_valid, win_col and win_row stable until out_ready.
//   - lb_write is combinational and equals accept exactly. The line buffer never sees a write without an accept.
//   Counters
//   - On accept: col increments; at col == IMG_WIDTH-1, col wraps to 0 and row increments.
//   - row wraps to 0 only via S_DONE.
//   Window rule
//   - legal = (row >= K-1) && (col >= K-1), evaluated on the pre-increment counters of the accepted pixel.
//   Outputs on accept
//   - On an accept that is legal: next cycle out_valid=1, win_col=col-(K-1), win_row=row-(K-1). Latency is 1 clock.
//   - On an accept with row >= K-1 but col < K-1: next cycle border=1 for one cycle; out_valid is not set.
//   - When out_valid && out_ready && no new legal accept: out_valid clears next cycle.
//   - Back-to-back legal accepts under out_ready=1 give continuous out_valid.
//   State machine
//   - S_FILL: rows 0..K-2 stream in to prime the buffer. No out_valid, no border.
//     -> S_ACTIVE when the accept at col==IMG_WIDTH-1, row==K-2 occurs.
//   - S_ACTIVE: windows and border produced per the rules above.
//     -> S_DONE on accept at col==IMG_WIDTH-1, row==IMG_HEIGHT-1.
//   - S_DONE: lasts exactly one cycle. in_ready=0; frame_done=1; col and row clear; -> S_FILL.
//     A pending out_valid from the last pixel is still held until out_ready.
//   Boundary conditions
//   - in_valid dropping mid-line freezes the counters; there is no timeout.
//   - out_ready low blocks in_ready, which also freezes lb_write. This keeps the buffer aligned.
//   - rst asserted mid-frame returns to S_FILL at col=row=0 and drops out_valid at once.
//     The line-buffer FIFOs are reset by the same rst.
//   - Arithmetic: win_col and win_row subtractions never underflow because of the legal gating.
//     Counters compare against IMG_*-1 and never exceed that value.
// TESTING  (IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL_WIDTH=3 unless noted)
//   1. Reset, then stream 48 pixels with in_valid=1 and out_ready=1.
//      -> lb_write count 48; out_valid count 24; border count 8; frame_done once, one cycle after pixel 48.
//   2. Same stream: check the first window.
//      -> First out_valid the cycle after pixel 19 (row2,col2) is accepted, with win_col=0, win_row=0.
//      -> Last window has win_col=5, win_row=3.
//   3. Hold out_ready=0 for 5 cycles while out_valid=1.
//      -> in_ready=0 and lb_write=0 for those cycles; win_col/win_row stable; no window lost or duplicated.
//   4. Random in_valid gaps (~30% idle).
//      -> Window sequence and coordinates identical to test 1; counters never advance on idle cycles.
//   5. Assert rst at pixel 30 (row3,col5).
//      -> out_valid=0 immediately; restreaming 48 pixels reproduces test 1 exactly.
//   6. Two frames back-to-back with K=5, W=H=8.
//      -> Per frame: 16 windows, 16 border pulses; in_ready=0 for exactly one cycle between frames.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
// Raster sequencer for the KERNEL_WIDTH-line buffer chain in front of the HOG
// gradient/cell stages. It tracks the column/row of each accepted pixel, gates
// line-buffer writes, and presents one window handshake (top-left coordinate)
// for every pixel that completes a full KERNEL_WIDTH x KERNEL_WIDTH window.
module line_buffer_ctrl #(
    parameter int IMG_WIDTH    = 854,
    parameter int IMG_HEIGHT   = 480,
    parameter int KERNEL_WIDTH = 3,
    localparam int COL_W = $clog2(IMG_WIDTH),
    localparam int ROW_W = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lb_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             border,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] KM1_C     = COL_W'(KERNEL_WIDTH - 1);
    localparam logic [ROW_W-1:0] KM1_R     = ROW_W'(KERNEL_WIDTH - 1);
    // Last row of the priming phase; its final pixel opens the active region.
    localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(KERNEL_WIDTH - 2);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col_p0;
    logic [ROW_W-1:0] row_p0;

    logic             vld_p1;
    logic [COL_W-1:0] win_col_p1;
    logic [ROW_W-1:0] win_row_p1;
    logic             border_p1;
    logic             frame_done_p1;

    logic accept;
    logic col_last;
    logic row_last;
    logic col_ready;
    logic row_ready;
    logic legal;
    logic edge_px;

    // Top-left column of the window whose bottom-right pixel sits at column c.
    // Only called for legal pixels, so c >= K-1 and the subtraction cannot wrap.
    function automatic logic [COL_W-1:0] win_col_of(input logic [COL_W-1:0] c);
        return c - KM1_C;
    endfunction

    // Top-left row of the window whose bottom-right pixel sits on row r.
    function automatic logic [ROW_W-1:0] win_row_of(input logic [ROW_W-1:0] r);
        return r - KM1_R;
    endfunction

    // Column after an accepted pixel; wraps at the end of the line.
    function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] c);
        return (c == COL_LAST) ? '0 : c + COL_W'(1);
    endfunction

    // No skid buffer: a new pixel is taken only when the window slot is free
    // or being drained this cycle, so the buffer never runs ahead of the consumer.
    assign in_ready = !rst && (state != S_DONE) && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;
    assign lb_write = accept;

    assign out_valid  = vld_p1;
    assign win_col    = win_col_p1;
    assign win_row    = win_row_p1;
    assign border     = border_p1;
    assign frame_done = frame_done_p1;

    // Decode the pre-increment position of the pixel being accepted this cycle.
    always_comb begin
        col_last  = (col_p0 == COL_LAST);
        row_last  = (row_p0 == ROW_LAST);
        col_ready = (col_p0 >= KM1_C);
        row_ready = (row_p0 >= KM1_R);
        legal     = accept && (state == S_ACTIVE) && row_ready && col_ready;
        edge_px   = accept && (state == S_ACTIVE) && row_ready && !col_ready;
    end

    // Frame sequencer: raster counters, window/border/frame_done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_FILL;
            col_p0        <= '0;
            row_p0        <= '0;
            vld_p1        <= 1'b0;
            win_col_p1    <= '0;
            win_row_p1    <= '0;
            border_p1     <= 1'b0;
            frame_done_p1 <= 1'b0;
        end else begin
            // ---- stage p0 -> p1: window handshake and edge pulses ----
            border_p1     <= edge_px;
            frame_done_p1 <= 1'b0;

            if (legal) begin
                vld_p1     <= 1'b1;
                win_col_p1 <= win_col_of(col_p0);
                win_row_p1 <= win_row_of(row_p0);
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end

            // ---- stage p0: raster position and frame phase ----
            case (state)
                S_FILL: begin
                    if (accept) begin
                        col_p0 <= col_next(col_p0);
                        if (col_last) begin
                            row_p0 <= row_p0 + ROW_W'(1);
                            if (row_p0 == ROW_PRIME) begin
                                state <= S_ACTIVE;
                            end
                        end
                    end
                end
                S_ACTIVE: begin
                    if (accept) begin
                        col_p0 <= col_next(col_p0);
                        if (col_last) begin
                            // The row counter parks on the last row; S_DONE clears it.
                            if (row_last) begin
                                state         <= S_DONE;
                                frame_done_p1 <= 1'b1;
                            end else begin
                                row_p0 <= row_p0 + ROW_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    col_p0 <= '0;
                    row_p0 <= '0;
                    state  <= S_FILL;
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Testbench for line_buffer_ctrl: 8x6 image, 3x3 kernel, plus an 8x8 / 5x5
// instance for back-to-back frames. Expected windows are pushed into a
// queue as pixels are accepted and popped when the DUT hands them over.
module tb_line_buffer_ctrl;

    localparam int W = 8;
    localparam int H = 6;
    localparam int K = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       lb_write;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] win_col;
    logic [2:0] win_row;
    logic       border;
    logic       frame_done;

    logic       in_valid2;
    logic       in_ready2;
    logic       lb_write2;
    logic       out_valid2;
    logic       out_ready2;
    logic [2:0] win_col2;
    logic [2:0] win_row2;
    logic       border2;
    logic       frame_done2;

    line_buffer_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_WIDTH(K)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .lb_write(lb_write), .out_valid(out_valid), .out_ready(out_ready),
        .win_col(win_col), .win_row(win_row), .border(border),
        .frame_done(frame_done)
    );

    line_buffer_ctrl #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .KERNEL_WIDTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .lb_write(lb_write2), .out_valid(out_valid2), .out_ready(out_ready2),
        .win_col(win_col2), .win_row(win_row2), .border(border2),
        .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model of the 8x6 instance
    int         m_col, m_row, m_state, m_accn, m_pops;
    bit         m_vld;
    logic [2:0] q_col[$];
    logic [2:0] q_row[$];

    // per-frame observations of the DUT
    int n_wr, n_win, n_bord, n_fd, first_acc, stall_blk;
    int first_wc, first_wr, last_wc, last_wr;

    task automatic model_clear();
        m_col = 0; m_row = 0; m_state = 0; m_accn = 0; m_pops = 0; m_vld = 0;
        q_col.delete(); q_row.delete();
        n_wr = 0; n_win = 0; n_bord = 0; n_fd = 0; first_acc = -1; stall_blk = 0;
        first_wc = -1; first_wr = -1; last_wc = -1; last_wr = -1;
    endtask

    // Streams one 8x6 frame. idle_pct: chance of an idle in_valid cycle;
    // stall_at: hold out_ready low 5 cycles when window #stall_at is presented;
    // rst_pix: assert rst right after that many pixels were accepted.
    task automatic run_frame(input int idle_pct, input int stall_at, input int rst_pix);
        int   cyc, tail, stall_left;
        bit   stalled, rst_done;
        logic v, r, e_ready, e_acc, nb, nf, nv;
        model_clear();
        cyc = 0; tail = -1; stall_left = 0; stalled = 0; rst_done = 0;
        while (tail != 0 && cyc < 2000) begin
            cyc++;
            v = ($urandom_range(0, 99) >= idle_pct);
            r = 1'b1;
            if (tail > 0) begin
                v = 1'b0;
                tail--;
            end
            if (!stalled && stall_at >= 0 && m_vld && m_pops == stall_at) begin
                stalled = 1; stall_left = 5;
            end
            if (stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end
            in_valid = v; out_ready = r;
            #1;
            e_ready = !rst && (m_state != 2) && (!m_vld || r);
            e_acc   = v && e_ready;
            n_cmp++;
            if (in_ready !== e_ready) begin
                n_bad++; $display("FAIL in_ready cyc %0d: got %b want %b", cyc, in_ready, e_ready);
            end
            n_cmp++;
            if (lb_write !== e_acc) begin
                n_bad++; $display("FAIL lb_write cyc %0d: got %b want %b", cyc, lb_write, e_acc);
            end
            if (m_vld && q_col.size() != 0) begin
                n_cmp++;
                if (win_col !== q_col[0] || win_row !== q_row[0]) begin
                    n_bad++;
                    $display("FAIL window cyc %0d: got (%0d,%0d) want (%0d,%0d)",
                             cyc, win_col, win_row, q_col[0], q_row[0]);
                end
            end
            if (lb_write === 1'b1) n_wr++;
            if (!r && in_ready === 1'b0) stall_blk++;
            if (out_valid === 1'b1 && r) begin
                if (n_win == 0) begin first_wc = int'(win_col); first_wr = int'(win_row); end
                last_wc = int'(win_col); last_wr = int'(win_row);
                n_win++;
            end
            // model update for this clock edge
            nb = 1'b0; nf = 1'b0; nv = m_vld;
            if (m_vld && r) begin
                nv = 1'b0; m_pops++;
                if (q_col.size() != 0) begin void'(q_col.pop_front()); void'(q_row.pop_front()); end
            end
            if (m_state == 2) begin
                m_col = 0; m_row = 0; m_state = 0;
            end else if (e_acc) begin
                m_accn++;
                if (m_row >= K - 1 && m_col >= K - 1) begin
                    nv = 1'b1;
                    q_col.push_back(3'(m_col - (K - 1)));
                    q_row.push_back(3'(m_row - (K - 1)));
                end
                if (m_row >= K - 1 && m_col < K - 1) nb = 1'b1;
                if (m_col == W - 1) begin
                    m_col = 0;
                    if (m_row == H - 1) begin m_state = 2; nf = 1'b1; end
                    else m_row++;
                end else begin
                    m_col++;
                end
            end
            m_vld = nv;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== m_vld) begin
                n_bad++; $display("FAIL out_valid cyc %0d: got %b want %b", cyc, out_valid, m_vld);
            end
            n_cmp++;
            if (border !== nb) begin
                n_bad++; $display("FAIL border cyc %0d: got %b want %b", cyc, border, nb);
            end
            n_cmp++;
            if (frame_done !== nf) begin
                n_bad++; $display("FAIL frame_done cyc %0d: got %b want %b", cyc, frame_done, nf);
            end
            if (border === 1'b1) n_bord++;
            if (frame_done === 1'b1) n_fd++;
            if (out_valid === 1'b1 && first_acc < 0) first_acc = n_wr;
            if (nf) tail = 2;
            if (rst_pix > 0 && !rst_done && m_accn == rst_pix) begin
                rst = 1'b1;
                #1;
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
                end
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
                end
                model_clear();
                rst_done = 1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (tail != 0) begin
            n_bad++; $display("FAIL frame_timeout: got %0d accepts want %0d", m_accn, W * H);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1; out_ready = 1'b1; in_valid2 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (lb_write !== 1'b0)   begin n_bad++; $display("FAIL reset_lb_write: got %b want 0", lb_write); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (border !== 1'b0)     begin n_bad++; $display("FAIL reset_border: got %b want 0", border); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (win_col !== 3'd0)    begin n_bad++; $display("FAIL reset_win_col: got %0d want 0", win_col); end
        n_cmp++; if (win_row !== 3'd0)    begin n_bad++; $display("FAIL reset_win_row: got %0d want 0", win_row); end
        n_cmp++; if (lb_write2 !== 1'b0)  begin n_bad++; $display("FAIL reset_lb_write2: got %b want 0", lb_write2); end
        in_valid = 1'b0; in_valid2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        run_frame(0, -1, 0);
        n_cmp++; if (n_wr != 48)  begin n_bad++; $display("FAIL full_writes: got %0d want 48", n_wr); end
        n_cmp++; if (n_win != 24) begin n_bad++; $display("FAIL full_windows: got %0d want 24", n_win); end
        n_cmp++; if (n_bord != 8) begin n_bad++; $display("FAIL full_borders: got %0d want 8", n_bord); end
        n_cmp++; if (n_fd != 1)   begin n_bad++; $display("FAIL full_frame_done: got %0d want 1", n_fd); end
    endtask

    task automatic test_first_last_window();
        run_frame(0, -1, 0);
        n_cmp++; if (first_acc != 19) begin n_bad++; $display("FAIL first_latency: got %0d want 19", first_acc); end
        n_cmp++; if (first_wc != 0 || first_wr != 0) begin
            n_bad++; $display("FAIL first_window: got (%0d,%0d) want (0,0)", first_wc, first_wr);
        end
        n_cmp++; if (last_wc != 5 || last_wr != 3) begin
            n_bad++; $display("FAIL last_window: got (%0d,%0d) want (5,3)", last_wc, last_wr);
        end
    endtask

    task automatic test_backpressure();
        run_frame(0, 3, 0);
        n_cmp++; if (stall_blk != 5) begin n_bad++; $display("FAIL stall_blocked: got %0d want 5", stall_blk); end
        n_cmp++; if (n_win != 24)    begin n_bad++; $display("FAIL stall_windows: got %0d want 24", n_win); end
        n_cmp++; if (n_wr != 48)     begin n_bad++; $display("FAIL stall_writes: got %0d want 48", n_wr); end
    endtask

    task automatic test_gaps();
        run_frame(30, -1, 0);
        n_cmp++; if (n_win != 24) begin n_bad++; $display("FAIL gap_windows: got %0d want 24", n_win); end
        n_cmp++; if (n_bord != 8) begin n_bad++; $display("FAIL gap_borders: got %0d want 8", n_bord); end
        n_cmp++; if (n_wr != 48)  begin n_bad++; $display("FAIL gap_writes: got %0d want 48", n_wr); end
        n_cmp++; if (last_wc != 5 || last_wr != 3) begin
            n_bad++; $display("FAIL gap_last_window: got (%0d,%0d) want (5,3)", last_wc, last_wr);
        end
    endtask

    task automatic test_mid_reset();
        run_frame(0, -1, 30);
        n_cmp++; if (n_wr != 48)   begin n_bad++; $display("FAIL rerun_writes: got %0d want 48", n_wr); end
        n_cmp++; if (n_win != 24)  begin n_bad++; $display("FAIL rerun_windows: got %0d want 24", n_win); end
        n_cmp++; if (n_bord != 8)  begin n_bad++; $display("FAIL rerun_borders: got %0d want 8", n_bord); end
        n_cmp++; if (n_fd != 1)    begin n_bad++; $display("FAIL rerun_frame_done: got %0d want 1", n_fd); end
        n_cmp++; if (first_acc != 19) begin n_bad++; $display("FAIL rerun_latency: got %0d want 19", first_acc); end
    endtask

    task automatic test_back_to_back();
        int w[2];
        int b[2];
        int fr, low, cyc, k, wr;
        w = '{0, 0}; b = '{0, 0}; fr = 0; low = 0; cyc = 0; wr = 0;
        in_valid2 = 1'b1;
        while (fr < 2 && cyc < 400) begin
            #1;
            if (lb_write2 === 1'b1) wr++;
            @(negedge clk);
            cyc++;
            if (out_valid2 === 1'b1) begin
                k = w[fr];
                n_cmp++;
                if (win_col2 !== 3'(k % 4) || win_row2 !== 3'(k / 4)) begin
                    n_bad++;
                    $display("FAIL k5_window f%0d #%0d: got (%0d,%0d) want (%0d,%0d)",
                             fr, k, win_col2, win_row2, k % 4, k / 4);
                end
                w[fr]++;
            end
            if (border2 === 1'b1) b[fr]++;
            if (frame_done2 === 1'b1) fr++;
            if (fr == 1 && in_ready2 !== 1'b1) low++;
        end
        in_valid2 = 1'b0;
        n_cmp++; if (fr != 2)     begin n_bad++; $display("FAIL k5_frames: got %0d want 2", fr); end
        n_cmp++; if (w[0] != 16)  begin n_bad++; $display("FAIL k5_windows_f0: got %0d want 16", w[0]); end
        n_cmp++; if (w[1] != 16)  begin n_bad++; $display("FAIL k5_windows_f1: got %0d want 16", w[1]); end
        n_cmp++; if (b[0] != 16)  begin n_bad++; $display("FAIL k5_borders_f0: got %0d want 16", b[0]); end
        n_cmp++; if (b[1] != 16)  begin n_bad++; $display("FAIL k5_borders_f1: got %0d want 16", b[1]); end
        n_cmp++; if (low != 1)    begin n_bad++; $display("FAIL k5_gap_cycles: got %0d want 1", low); end
        n_cmp++; if (wr != 128)   begin n_bad++; $display("FAIL k5_writes: got %0d want 128", wr); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        test_reset();
        test_full_frame();
        test_first_last_window();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
